// File: rtl/uart_bmpg_dump_if.sv
// Command and memory-read bundle between a host and the UART dump engine.
// The slave modport is the engine's view; master is the host/memory side.
interface uart_bmpg_dump_if;
    logic        dump_start_i;
    logic [14:0] dump_base_i;
    logic [14:0] dump_len_i;
    logic        mem_rd_o;
    logic [14:0] mem_adr_o;
    logic [31:0] mem_dat_i;
    logic        dump_busy_o;
    logic        dump_done_o;
    logic [1:0]  state_dbg_o;

    // Handshake: a start is taken only in IDLE; busy covers the whole dump,
    // done pulses for one cycle after the last stop bit.
    // mem_rd_o is a one-cycle strobe; mem_dat_i must be valid the next cycle.
    modport slave (
        input  dump_start_i, dump_base_i, dump_len_i, mem_dat_i,
        output mem_rd_o, mem_adr_o, dump_busy_o, dump_done_o, state_dbg_o
    );

    modport master (
        output dump_start_i, dump_base_i, dump_len_i, mem_dat_i,
        input  mem_rd_o, mem_adr_o, dump_busy_o, dump_done_o, state_dbg_o
    );
endinterface

// File: rtl/uart_bmpg_dump.sv
// Reads a range of 32-bit words from ROM/dmem and sends each one as four
// 8N1 bytes, LSB first, on a registered TX line.
module uart_bmpg_dump #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic                upg_clk_i,
    input  logic                upg_rst_i,
    uart_bmpg_dump_if.slave     bus,
    output logic                upg_tx_o
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, READ, LATCH, SHIFT} state_t;

    state_t        state_q, state_d;
    logic [14:0]   adr_q, adr_d;
    logic [14:0]   cnt_q, cnt_d;
    logic [31:0]   shift_q, shift_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;

    always_ff @(posedge upg_clk_i or negedge upg_rst_i) begin
        if (!upg_rst_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.dump_start_i) begin
                    if (bus.dump_len_i != 15'd0) begin
                        adr_d   = bus.dump_base_i;
                        cnt_d   = bus.dump_len_i;
                        state_d = READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: state_d = LATCH;
            LATCH: begin
                // Start bit of byte 0 goes out on the same edge the word lands.
                shift_d = bus.mem_dat_i;
                bit_d   = '0;
                byte_d  = '0;
                baud_d  = '0;
                tx_d    = 1'b0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 4'd9) begin
                        if (byte_q == 2'd3) begin
                            adr_d   = adr_q + 15'd1;
                            cnt_d   = cnt_q - 15'd1;
                            tx_d    = 1'b1;
                            done_d  = (cnt_q == 15'd1);
                            state_d = (cnt_q == 15'd1) ? IDLE : READ;
                        end else begin
                            byte_d  = byte_q + 2'd1;
                            bit_d   = '0;
                            shift_d = {8'h00, shift_q[31:8]};
                            tx_d    = 1'b0;
                        end
                    end else begin
                        // bit_q k (0..7) is followed by data bit k; bit 8 by the stop bit.
                        bit_d = bit_q + 4'd1;
                        tx_d  = (bit_q == 4'd8) ? 1'b1 : shift_q[bit_q[2:0]];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_rd_o    = (state_q == READ);
    assign bus.mem_adr_o   = adr_q;
    assign bus.dump_busy_o = (state_q != IDLE);
    assign bus.dump_done_o = done_q;
    assign bus.state_dbg_o = state_q;
    assign upg_tx_o        = tx_q;

endmodule
